// File: rtl/comparator_result_tracker.sv
// comparator_result_tracker
// Samples the one-hot EQUAL/LESS/HIGHER result of a 4-bit comparator on each
// IN_VALID strobe, keeps saturating per-result counts, tracks the run length
// of identical consecutive results and latches a sticky illegal-code flag.
// All outputs come straight from registers.
module comparator_result_tracker #(
    parameter int CNT_WIDTH  = 8,
    parameter int STREAK_LEN = 4
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    input  logic                 EQUAL,
    input  logic                 LESS,
    input  logic                 HIGHER,
    input  logic                 CLEAR,
    output logic [CNT_WIDTH-1:0] EQ_COUNT,
    output logic [CNT_WIDTH-1:0] LT_COUNT,
    output logic [CNT_WIDTH-1:0] GT_COUNT,
    output logic [1:0]           LAST_RESULT,
    output logic [CNT_WIDTH-1:0] STREAK,
    output logic                 STREAK_HIT,
    output logic                 CODE_ERROR
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RUN_EQ = 3'd1,
        RUN_LT = 3'd2,
        RUN_GT = 3'd3,
        FAULT  = 3'd4
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] HIT_AT   = CNT_WIDTH'(STREAK_LEN);
    localparam logic [CNT_WIDTH-1:0] ONE      = CNT_WIDTH'(1);

    // Index 0 = EQ, 1 = LT, 2 = GT throughout.
    state_t               state_reg;
    logic [CNT_WIDTH-1:0] cnt_reg [3];
    logic [CNT_WIDTH-1:0] cnt_next [3];
    logic [CNT_WIDTH-1:0] streak_reg;
    logic [CNT_WIDTH-1:0] streak_next;
    logic [1:0]           last_reg;
    logic                 hit_reg;
    logic                 hit_next;
    logic                 error_reg;

    logic [2:0]           sel;
    logic                 legal;
    logic                 same_run;
    logic [1:0]           code;
    state_t               run_state;

    assign sel = {HIGHER, LESS, EQUAL};

    // Per-result saturating increment; only the selected counter advances.
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            always_comb begin
                cnt_next[gi] = cnt_reg[gi];
                if (sel[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_next[gi] = cnt_reg[gi] + ONE;
                end
            end
        end
    endgenerate

    // Decode the sampled code and work out the run-length update.
    always_comb begin
        legal     = (sel == 3'b001) || (sel == 3'b010) || (sel == 3'b100);
        code      = 2'b00;
        run_state = IDLE;
        if (EQUAL) begin
            code      = 2'b01;
            run_state = RUN_EQ;
        end else if (LESS) begin
            code      = 2'b10;
            run_state = RUN_LT;
        end else if (HIGHER) begin
            code      = 2'b11;
            run_state = RUN_GT;
        end
        same_run = (state_reg == run_state) && (run_state != IDLE);
        if (same_run) begin
            streak_next = (streak_reg == CNT_MAX) ? streak_reg : streak_reg + ONE;
        end else begin
            streak_next = ONE;
        end
        // Fire only on the transition into STREAK_LEN, never while holding there.
        hit_next = (streak_next == HIT_AT) && (streak_reg != HIT_AT);
    end

    // Result-tracking FSM with counters, streak and flags as registered outputs.
    always_ff @(posedge CLK) begin
        if (RST || CLEAR) begin
            state_reg  <= IDLE;
            streak_reg <= '0;
            last_reg   <= 2'b00;
            hit_reg    <= 1'b0;
            error_reg  <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                cnt_reg[i] <= '0;
            end
        end else begin
            hit_reg <= 1'b0;
            if (IN_VALID && (state_reg != FAULT)) begin
                if (!legal) begin
                    state_reg  <= FAULT;
                    error_reg  <= 1'b1;
                    streak_reg <= '0;
                    last_reg   <= 2'b00;
                end else begin
                    state_reg  <= run_state;
                    streak_reg <= streak_next;
                    last_reg   <= code;
                    hit_reg    <= hit_next;
                    for (int i = 0; i < 3; i++) begin
                        cnt_reg[i] <= cnt_next[i];
                    end
                end
            end
        end
    end

    assign EQ_COUNT    = cnt_reg[0];
    assign LT_COUNT    = cnt_reg[1];
    assign GT_COUNT    = cnt_reg[2];
    assign LAST_RESULT = last_reg;
    assign STREAK      = streak_reg;
    assign STREAK_HIT  = hit_reg;
    assign CODE_ERROR  = error_reg;

endmodule

// File: tb/tb_comparator_result_tracker.sv
// Directed testbench for comparator_result_tracker: a default-width instance
// plus a 3-bit instance for saturation, both driven from the same inputs.
module tb_comparator_result_tracker;

    logic clk = 1'b0;
    logic rst, in_valid, equal, less, higher, clear;

    logic [7:0] eq_count, lt_count, gt_count, streak;
    logic [1:0] last_result;
    logic       streak_hit, code_error;

    logic [2:0] s_eq_count, s_lt_count, s_gt_count, s_streak;
    logic [1:0] s_last_result;
    logic       s_streak_hit, s_code_error;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    comparator_result_tracker #(.CNT_WIDTH(8), .STREAK_LEN(4)) dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .EQUAL(equal), .LESS(less),
        .HIGHER(higher), .CLEAR(clear), .EQ_COUNT(eq_count), .LT_COUNT(lt_count),
        .GT_COUNT(gt_count), .LAST_RESULT(last_result), .STREAK(streak),
        .STREAK_HIT(streak_hit), .CODE_ERROR(code_error)
    );

    comparator_result_tracker #(.CNT_WIDTH(3), .STREAK_LEN(4)) u_small (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .EQUAL(equal), .LESS(less),
        .HIGHER(higher), .CLEAR(clear), .EQ_COUNT(s_eq_count), .LT_COUNT(s_lt_count),
        .GT_COUNT(s_gt_count), .LAST_RESULT(s_last_result), .STREAK(s_streak),
        .STREAK_HIT(s_streak_hit), .CODE_ERROR(s_code_error)
    );

    // Apply one cycle of inputs; outputs are looked at 1 time unit after the edge.
    task automatic drive(input logic v, input logic [2:0] gle, input logic c, input logic r);
        in_valid = v;
        higher   = gle[2];
        less     = gle[1];
        equal    = gle[0];
        clear    = c;
        rst      = r;
        @(posedge clk);
        #1;
        in_valid = 1'b0; equal = 1'b0; less = 1'b0; higher = 1'b0;
        clear = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        drive(1'b0, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if ({eq_count, lt_count, gt_count, streak} !== 32'h0 || last_result !== 2'b00
            || code_error !== 1'b0 || streak_hit !== 1'b0) begin
            errors++;
            $display("FAIL reset: eq=%0d lt=%0d gt=%0d streak=%0d last=%b err=%b hit=%b want all 0",
                     eq_count, lt_count, gt_count, streak, last_result, code_error, streak_hit);
        end else $display("reset: all outputs 0");
    endtask

    task automatic test_compare;
        logic [3:0] a_tab [5] = '{4'd0, 4'd5, 4'd8, 4'd0, 4'd3};
        logic [3:0] b_tab [5] = '{4'd0, 4'd0, 4'd15, 4'd1, 4'd3};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, {a_tab[i] > b_tab[i], a_tab[i] < b_tab[i], a_tab[i] == b_tab[i]}, 1'b0, 1'b0);
            $display("compare a=%0d b=%0d -> eq=%0d lt=%0d gt=%0d last=%b streak=%0d",
                     a_tab[i], b_tab[i], eq_count, lt_count, gt_count, last_result, streak);
        end
        checks++;
        if (eq_count !== 8'd2 || lt_count !== 8'd2 || gt_count !== 8'd1) begin
            errors++;
            $display("FAIL compare_counts: eq=%0d lt=%0d gt=%0d want 2 2 1", eq_count, lt_count, gt_count);
        end
        checks++;
        if (last_result !== 2'b01 || streak !== 8'd1) begin
            errors++;
            $display("FAIL compare_last: last=%b streak=%0d want 01 1", last_result, streak);
        end
        // Idle cycle: everything holds and no pulse.
        drive(1'b0, 3'b010, 1'b0, 1'b0);
        checks++;
        if (eq_count !== 8'd2 || lt_count !== 8'd2 || streak !== 8'd1 || streak_hit !== 1'b0) begin
            errors++;
            $display("FAIL idle_hold: eq=%0d lt=%0d streak=%0d hit=%b want 2 2 1 0",
                     eq_count, lt_count, streak, streak_hit);
        end
    endtask

    task automatic test_streak;
        logic exp_hit;
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 3'b010, 1'b0, 1'b0);
            exp_hit = (i == 4);
            $display("streak LT #%0d: streak=%0d hit=%b lt=%0d", i, streak, streak_hit, lt_count);
            checks++;
            if (streak !== 8'(i) || streak_hit !== exp_hit) begin
                errors++;
                $display("FAIL streak_%0d: streak=%0d hit=%b want %0d %b", i, streak, streak_hit, i, exp_hit);
            end
        end
        checks++;
        if (lt_count !== 8'd5 || last_result !== 2'b10) begin
            errors++;
            $display("FAIL streak_count: lt=%0d last=%b want 5 10", lt_count, last_result);
        end
    endtask

    task automatic test_back_to_back;
        // New GT run after the LT run must re-fire at its own 4th sample.
        for (int i = 1; i <= 4; i++) drive(1'b1, 3'b100, 1'b0, 1'b0);
        checks++;
        if (streak_hit !== 1'b1 || streak !== 8'd4 || gt_count !== 8'd4 || last_result !== 2'b11) begin
            errors++;
            $display("FAIL back_to_back: hit=%b streak=%0d gt=%0d last=%b want 1 4 4 11",
                     streak_hit, streak, gt_count, last_result);
        end else $display("back_to_back: GT run re-fired hit");
        drive(1'b0, 3'b000, 1'b0, 1'b0);
        checks++;
        if (streak_hit !== 1'b0) begin
            errors++;
            $display("FAIL hit_pulse: hit=%b want 0", streak_hit);
        end
    endtask

    task automatic test_fault;
        drive(1'b1, 3'b110, 1'b0, 1'b0);
        checks++;
        if (code_error !== 1'b1 || streak !== 8'd0 || last_result !== 2'b00
            || lt_count !== 8'd5 || gt_count !== 8'd4) begin
            errors++;
            $display("FAIL fault_entry: err=%b streak=%0d last=%b lt=%0d gt=%0d want 1 0 00 5 4",
                     code_error, streak, last_result, lt_count, gt_count);
        end else $display("fault: illegal code latched");
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        drive(1'b1, 3'b010, 1'b0, 1'b0);
        drive(1'b1, 3'b100, 1'b0, 1'b0);
        checks++;
        if (eq_count !== 8'd0 || lt_count !== 8'd5 || gt_count !== 8'd4
            || code_error !== 1'b1 || streak !== 8'd0) begin
            errors++;
            $display("FAIL fault_frozen: eq=%0d lt=%0d gt=%0d err=%b streak=%0d want 0 5 4 1 0",
                     eq_count, lt_count, gt_count, code_error, streak);
        end
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        checks++;
        if ({eq_count, lt_count, gt_count, streak} !== 32'h0 || code_error !== 1'b0
            || last_result !== 2'b00) begin
            errors++;
            $display("FAIL fault_clear: eq=%0d lt=%0d gt=%0d streak=%0d err=%b last=%b want all 0",
                     eq_count, lt_count, gt_count, streak, code_error, last_result);
        end
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        checks++;
        if (eq_count !== 8'd1 || last_result !== 2'b01 || streak !== 8'd1) begin
            errors++;
            $display("FAIL fault_recover: eq=%0d last=%b streak=%0d want 1 01 1",
                     eq_count, last_result, streak);
        end
    endtask

    task automatic test_saturation;
        drive(1'b0, 3'b000, 1'b1, 1'b0);
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 3'b100, 1'b0, 1'b0);
            $display("sat GT #%0d: gt=%0d streak=%0d hit=%b", i, s_gt_count, s_streak, s_streak_hit);
        end
        checks++;
        if (s_gt_count !== 3'd7 || s_streak !== 3'd7 || s_streak_hit !== 1'b0) begin
            errors++;
            $display("FAIL sat_hold: gt=%0d streak=%0d hit=%b want 7 7 0", s_gt_count, s_streak, s_streak_hit);
        end
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        checks++;
        if (s_eq_count !== 3'd1 || s_streak !== 3'd1 || s_gt_count !== 3'd7 || s_last_result !== 2'b01) begin
            errors++;
            $display("FAIL sat_switch: eq=%0d streak=%0d gt=%0d last=%b want 1 1 7 01",
                     s_eq_count, s_streak, s_gt_count, s_last_result);
        end
        checks++;
        if (gt_count !== 8'd9 || eq_count !== 8'd1) begin
            errors++;
            $display("FAIL wide_count: gt=%0d eq=%0d want 9 1", gt_count, eq_count);
        end
    endtask

    task automatic test_priority;
        drive(1'b1, 3'b001, 1'b1, 1'b0);
        checks++;
        if (eq_count !== 8'd0 || gt_count !== 8'd0 || last_result !== 2'b00) begin
            errors++;
            $display("FAIL clear_drop: eq=%0d gt=%0d last=%b want 0 0 00", eq_count, gt_count, last_result);
        end else $display("priority: CLEAR drops sample");
        drive(1'b1, 3'b001, 1'b0, 1'b0);
        drive(1'b1, 3'b001, 1'b0, 1'b1);
        checks++;
        if (eq_count !== 8'd0 || streak !== 8'd0 || last_result !== 2'b00) begin
            errors++;
            $display("FAIL rst_drop: eq=%0d streak=%0d last=%b want 0 0 00", eq_count, streak, last_result);
        end else $display("priority: RST drops sample");
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; equal = 1'b0; less = 1'b0; higher = 1'b0; clear = 1'b0;
        @(negedge clk);
        test_reset;
        test_compare;
        test_streak;
        test_back_to_back;
        test_fault;
        test_saturation;
        test_priority;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
